valid_pipe_credit_receiver: RTL and testbench

// Receiving end of a valid-only pipeline such as shift_register_with_valid or sqrt_formula_pipe.

---
 rtl/valid_pipe_credit_receiver.sv | 68 ++++++
 tb/tb_valid_pipe_credit_receiver.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/valid_pipe_credit_receiver.sv
// valid_pipe_credit_receiver: buffers results of a no-backpressure pipeline in a FIFO
// and issues launch credits so that in-flight results always fit.
module valid_pipe_credit_receiver #(
  parameter int width = 8,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     launch_rdy,
  input  logic                     launch_vld,
  input  logic                     pipe_vld,
  input  logic [width-1:0]         pipe_data,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [width-1:0]         out_data,
  output logic [$clog2(depth):0]   count,
  output logic [$clog2(depth):0]   reserved,
  output logic                     err_launch,
  output logic                     err_ovf
);
  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(depth);
  logic [width-1:0] mem_q [depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, reserved_q, reserved_d;
  logic err_launch_q, err_launch_d, err_ovf_q, err_ovf_d;
  logic launch, pop, push;
  assign launch_rdy = ~rst & (reserved_q < FULL);
  assign out_vld    = count_q != '0;
  assign out_data   = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign reserved   = reserved_q;
  assign err_launch = err_launch_q;
  assign err_ovf    = err_ovf_q;
  assign launch     = launch_vld & launch_rdy;
  assign pop        = out_vld & out_rdy;
  // a pop in the same cycle frees the slot a full FIFO needs for the push
  assign push       = pipe_vld & ((count_q < FULL) | pop);
  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d      = count_q + CW'(push) - CW'(pop);
    reserved_d   = reserved_q + CW'(launch) - CW'(pop);
    err_launch_d = err_launch_q | (launch_vld & ~launch_rdy);
    err_ovf_d    = err_ovf_q | (pipe_vld & ~push);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      reserved_q   <= '0;
      err_launch_q <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      reserved_q   <= reserved_d;
      err_launch_q <= err_launch_d;
      err_ovf_q    <= err_ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pipe_data;
  end
endmodule

// File: tb/tb_valid_pipe_credit_receiver.sv
// tb_valid_pipe_credit_receiver: directed checks of the credit receiver with a latency-4 pipe model.
module tb_valid_pipe_credit_receiver;
  logic clk = 1'b0;
  logic rst;
  logic launch_rdy, launch_vld, pipe_vld, out_vld, out_rdy, err_launch, err_ovf;
  logic [7:0] pipe_data, out_data;
  logic [3:0] count, reserved;
  logic use_pipe, pvld_m;
  logic [7:0] pdat_m, ldat;
  logic [3:0] pv = '0;
  logic [7:0] d0, d1, d2, d3;
  int checks = 0;
  int errors = 0;
  int nv, rx;
  logic tog;
  logic [7:0] exp_q [8];

  valid_pipe_credit_receiver #(.width(8), .depth(8)) dut (
    .clk(clk), .rst(rst), .launch_rdy(launch_rdy), .launch_vld(launch_vld),
    .pipe_vld(pipe_vld), .pipe_data(pipe_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .count(count), .reserved(reserved),
    .err_launch(err_launch), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pv <= {pv[2:0], launch_vld & use_pipe};
    d0 <= ldat;
    d1 <= d0;
    d2 <= d1;
    d3 <= d2;
  end
  assign pipe_vld  = use_pipe ? pv[3] : pvld_m;
  assign pipe_data = use_pipe ? d3 : pdat_m;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; launch_vld = 1'b0; out_rdy = 1'b0; use_pipe = 1'b0;
    pvld_m = 1'b0; pdat_m = '0; ldat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_count", count, 0);
    chk("rst_reserved", reserved, 0);
    chk("rst_launch_rdy", launch_rdy, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_launch_rdy", launch_rdy, 1);
    step;
    // ordered stream through latency-4 pipe, out_rdy toggling
    use_pipe = 1'b1; nv = 0; rx = 0; tog = 1'b1;
    for (int c = 0; c < 300 && rx < 20; c++) begin
      out_rdy = tog;
      tog = ~tog;
      launch_vld = (nv < 20) && launch_rdy;
      ldat = 8'(nv);
      if (launch_vld) nv++;
      if (out_vld && out_rdy) begin
        chk("order", out_data, rx);
        rx++;
      end
      step;
    end
    launch_vld = 1'b0; out_rdy = 1'b0;
    chk("stream_received", rx, 20);
    chk("stream_count", count, 0);
    chk("stream_reserved", reserved, 0);
    chk("stream_err_ovf", err_ovf, 0);
    use_pipe = 1'b0;
    // credit exhaustion
    launch_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("credit_rdy", launch_rdy, 1);
      step;
    end
    chk("credit_exhausted", launch_rdy, 0);
    chk("credit_reserved", reserved, 8);
    launch_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pvld_m = 1'b1;
      pdat_m = 8'hA0 + 8'(i);
      step;
    end
    pvld_m = 1'b0;
    chk("fill_count", count, 8);
    chk("fill_err_ovf", err_ovf, 0);
    chk("fill_err_launch", err_launch, 0);
    chk("fill_head", out_data, 8'hA0);
    // full with simultaneous push and pop
    pvld_m = 1'b1; pdat_m = 8'h55; out_rdy = 1'b1;
    step;
    pvld_m = 1'b0; out_rdy = 1'b0;
    chk("full_pp_count", count, 8);
    chk("full_pp_reserved", reserved, 7);
    chk("full_pp_head", out_data, 8'hA1);
    chk("full_pp_err_ovf", err_ovf, 0);
    // violations
    launch_vld = 1'b1;
    step;
    chk("viol_rdy_low", launch_rdy, 0);
    step;
    launch_vld = 1'b0;
    chk("viol_err_launch", err_launch, 1);
    chk("viol_reserved", reserved, 8);
    pvld_m = 1'b1; pdat_m = 8'hEE;
    step;
    pvld_m = 1'b0;
    chk("viol_err_ovf", err_ovf, 1);
    chk("viol_count", count, 8);
    chk("viol_head", out_data, 8'hA1);
    for (int i = 0; i < 7; i++) exp_q[i] = 8'hA1 + 8'(i);
    exp_q[7] = 8'h55;
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", out_data, exp_q[i]);
      step;
    end
    out_rdy = 1'b0;
    chk("drain_count", count, 0);
    chk("drain_reserved", reserved, 0);
    chk("drain_out_vld", out_vld, 0);
    // mid-operation asynchronous reset
    launch_vld = 1'b1;
    repeat (8) step;
    launch_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pvld_m = 1'b1;
      pdat_m = 8'h30 + 8'(i);
      step;
    end
    pvld_m = 1'b0;
    chk("mid_count", count, 5);
    chk("mid_reserved", reserved, 8);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_vld", out_vld, 0);
    chk("arst_count", count, 0);
    chk("arst_reserved", reserved, 0);
    chk("arst_launch_rdy", launch_rdy, 0);
    chk("arst_err_launch", err_launch, 0);
    chk("arst_err_ovf", err_ovf, 0);
    pvld_m = 1'b1; pdat_m = 8'h77;
    step;
    step;
    chk("rst_ignore_count", count, 0);
    chk("rst_ignore_out_vld", out_vld, 0);
    pvld_m = 1'b0;
    rst = 1'b0;
    step;
    chk("release_count", count, 0);
    chk("release_reserved", reserved, 0);
    chk("release_launch_rdy", launch_rdy, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
